fetch_unit: RTL

//   Instruction-fetch stage directly downstream of PC: takes the current PC value (PC_out -> pc_in),

---
 rtl/fetch_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage between PC and decode (req/ack imem, valid/ready decode)
// Optional macro FETCH_TIMEOUT_EN adds a WAIT/DRAIN ack timeout with sticky timeout_err.
module fetch_unit #(
  parameter int XLEN = 32
`ifdef FETCH_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  output logic            pc_stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic            misaligned
`ifdef FETCH_TIMEOUT_EN
  , output logic          timeout_err
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  state_t state;
  logic   timed_out;

  // A redirect or an accepted instruction are the only cycles PC may advance.
  assign pc_stall = !(flush || (state == ST_HOLD && inst_ready));

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign timed_out = (state == ST_WAIT || state == ST_DRAIN) && !imem_ack && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (timed_out)
        timeout_err <= 1'b1;
      // Moving from WAIT into DRAIN restarts the wait budget.
      if (state == ST_WAIT && !imem_ack && flush)
        cnt <= '0;
      else if ((state == ST_WAIT || state == ST_DRAIN) && !imem_ack)
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      inst_out   <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!flush) begin
            if (pc_in[1:0] != 2'b00) begin
              misaligned <= 1'b1;
              state      <= ST_ERR;
            end else begin
              imem_addr <= pc_in;
              imem_req  <= 1'b1;
              state     <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            if (!flush) begin
              inst_out   <= imem_rdata;
              inst_pc    <= imem_addr;
              inst_valid <= 1'b1;
              state      <= ST_HOLD;
            end else begin
              state <= ST_IDLE;
            end
          end else if (timed_out) begin
            imem_req <= 1'b0;
            state    <= ST_ERR;
          end else if (flush) begin
            // The request cannot be withdrawn before ack; drain and drop it.
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= ST_IDLE;
          end else if (timed_out) begin
            imem_req <= 1'b0;
            state    <= ST_ERR;
          end
        end
        ST_HOLD: begin
          if (flush || inst_ready) begin
            inst_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        ST_ERR: begin
          if (flush) begin
            misaligned <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
